huffman_decoder: RTL and testbench

- Companion to the 6-symbol Huffman encoder: consumes the encoder's code table (HC1..HC6, M1..M6, qualified by code_valid) and a serial bitstream, and emits decoded symbol indices 1..6.
- Sits downstream of the encoder in the gray-level compression path; used for loopback verification and for the decompression side.
- One bit per cycle max; decoding uses prefix matching against the registered table.

---
 rtl/huffman_decoder_if.sv | 25 ++
 rtl/huffman_decoder.sv | 129 ++++++++++++
 tb/tb_huffman_decoder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/huffman_decoder_if.sv
// Table, serial-bit and decoded-symbol signals between a bitstream source and huffman_decoder.
// The master drives the code table and bits; the slave (decoder) returns symbols and status.
interface huffman_decoder_if;
   logic       code_valid;
   logic [7:0] HC1, HC2, HC3, HC4, HC5, HC6;
   logic [7:0] M1, M2, M3, M4, M5, M6;
   logic       bit_valid;
   logic       bit_data;
   logic       table_ready;
   logic       sym_valid;
   logic [7:0] sym_data;
   logic       code_err;

   modport master (
      output code_valid, HC1, HC2, HC3, HC4, HC5, HC6, M1, M2, M3, M4, M5, M6,
      output bit_valid, bit_data,
      input  table_ready, sym_valid, sym_data, code_err
   );

   modport slave (
      input  code_valid, HC1, HC2, HC3, HC4, HC5, HC6, M1, M2, M3, M4, M5, M6,
      input  bit_valid, bit_data,
      output table_ready, sym_valid, sym_data, code_err
   );
endinterface

// File: rtl/huffman_decoder.sv
// Serial 6-symbol Huffman decoder: prefix-matches incoming bits against a registered code table.
// Define HUFF_DEC_ERR_EN to drive code_err on an invalid MAX_LEN prefix; otherwise it is tied 0.
module huffman_decoder #(
   parameter int unsigned MAX_LEN = 5,
   parameter int unsigned NSYM    = 6
) (
   input logic               clk,
   input logic               reset,
   huffman_decoder_if.slave  bus
);

   typedef enum logic {StIdle, StDecode} state_t;

   state_t             r_state;
   logic [MAX_LEN-1:0] r_hc [NSYM];
   logic [MAX_LEN-1:0] r_m  [NSYM];
   logic [MAX_LEN-1:0] r_acc;
   logic [MAX_LEN-1:0] r_lm;
   logic               r_table_ready;
   logic               r_sym_valid;
   logic [7:0]         r_sym_data;

   logic [MAX_LEN-1:0] w_hc_in [NSYM];
   logic [MAX_LEN-1:0] w_m_in  [NSYM];
   logic [MAX_LEN-1:0] w_acc_next;
   logic [MAX_LEN-1:0] w_lm_next;
   logic               w_full;
   logic               w_hit;
   logic [7:0]         w_sym;
   logic               w_unused;

   always_comb begin
      w_hc_in[0] = bus.HC1[MAX_LEN-1:0];
      w_hc_in[1] = bus.HC2[MAX_LEN-1:0];
      w_hc_in[2] = bus.HC3[MAX_LEN-1:0];
      w_hc_in[3] = bus.HC4[MAX_LEN-1:0];
      w_hc_in[4] = bus.HC5[MAX_LEN-1:0];
      w_hc_in[5] = bus.HC6[MAX_LEN-1:0];
      w_m_in[0]  = bus.M1[MAX_LEN-1:0];
      w_m_in[1]  = bus.M2[MAX_LEN-1:0];
      w_m_in[2]  = bus.M3[MAX_LEN-1:0];
      w_m_in[3]  = bus.M4[MAX_LEN-1:0];
      w_m_in[4]  = bus.M5[MAX_LEN-1:0];
      w_m_in[5]  = bus.M6[MAX_LEN-1:0];
   end

   // Only MAX_LEN code bits matter; the top accumulator bits are never shifted back in.
   assign w_unused = ^{bus.HC1[7:MAX_LEN], bus.HC2[7:MAX_LEN], bus.HC3[7:MAX_LEN],
                       bus.HC4[7:MAX_LEN], bus.HC5[7:MAX_LEN], bus.HC6[7:MAX_LEN],
                       bus.M1[7:MAX_LEN], bus.M2[7:MAX_LEN], bus.M3[7:MAX_LEN],
                       bus.M4[7:MAX_LEN], bus.M5[7:MAX_LEN], bus.M6[7:MAX_LEN],
                       r_acc[MAX_LEN-1], r_lm[MAX_LEN-1]};

   assign w_acc_next = {r_acc[MAX_LEN-2:0], bus.bit_data};
   assign w_lm_next  = {r_lm[MAX_LEN-2:0], 1'b1};
   assign w_full     = &w_lm_next;

   // Scan from the top so the lowest matching index is the one left standing.
   always_comb begin
      w_hit = 1'b0;
      w_sym = 8'd0;
      for (int i = int'(NSYM) - 1; i >= 0; i--) begin
         if (r_m[i] == w_lm_next && r_hc[i] == w_acc_next) begin
            w_hit = 1'b1;
            w_sym = 8'(i + 1);
         end
      end
   end

`ifdef HUFF_DEC_ERR_EN
   logic r_code_err;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= StIdle;
         r_hc          <= '{default: '0};
         r_m           <= '{default: '0};
         r_acc         <= '0;
         r_lm          <= '0;
         r_table_ready <= 1'b0;
         r_sym_valid   <= 1'b0;
         r_sym_data    <= 8'd0;
`ifdef HUFF_DEC_ERR_EN
         r_code_err    <= 1'b0;
`endif
      end else begin
         r_sym_valid <= 1'b0;
`ifdef HUFF_DEC_ERR_EN
         r_code_err  <= 1'b0;
`endif
         // A table load always wins over a bit arriving in the same cycle.
         if (bus.code_valid) begin
            r_state       <= StDecode;
            r_hc          <= w_hc_in;
            r_m           <= w_m_in;
            r_acc         <= '0;
            r_lm          <= '0;
            r_table_ready <= 1'b1;
         end else if (r_state == StDecode && bus.bit_valid) begin
            if (w_hit) begin
               r_sym_valid <= 1'b1;
               r_sym_data  <= w_sym;
               r_acc       <= '0;
               r_lm        <= '0;
            end else if (w_full) begin
               r_acc <= '0;
               r_lm  <= '0;
`ifdef HUFF_DEC_ERR_EN
               r_code_err <= 1'b1;
`endif
            end else begin
               r_acc <= w_acc_next;
               r_lm  <= w_lm_next;
            end
         end
      end
   end

   assign bus.table_ready = r_table_ready;
   assign bus.sym_valid   = r_sym_valid;
   assign bus.sym_data    = r_sym_data;
`ifdef HUFF_DEC_ERR_EN
   assign bus.code_err    = r_code_err;
`else
   assign bus.code_err    = 1'b0;
`endif

endmodule

// File: tb/tb_huffman_decoder.sv
// Bench for huffman_decoder: fixed codeword vectors, hand sequences and random traffic,
// every cycle compared against a bit-queue reference model of the prefix-matching rules.
module tb_huffman_decoder;

`ifdef HUFF_DEC_ERR_EN
   localparam bit ErrEn = 1'b1;
`else
   localparam bit ErrEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   huffman_decoder_if bus ();

   huffman_decoder #(.MAX_LEN(5), .NSYM(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] tbl_hc [6];
   logic [7:0] tbl_m  [6];

   // Reference model state
   logic [7:0] m_hc [6];
   logic [7:0] m_m  [6];
   bit         m_loaded;
   int         q[$];
   bit         e_sv, e_err;
   logic [7:0] e_data;

   int got[$];
   int got_err;

   typedef struct {
      string           name;
      bit              off6;
      int              nbits;
      logic [15:0]     bits;
      int              gap_at;
      int              gap_len;
      int              nexp;
      logic [3:0][7:0] exp_s;
      int              exp_err;
   } vec_t;

   vec_t vecs[$];

   function automatic void load_t(input bit off6);
      tbl_hc = '{8'h00, 8'h02, 8'h06, 8'h0E, 8'h1E, 8'h1F};
      tbl_m  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F};
      if (off6) begin
         tbl_hc[5] = 8'h00;
         tbl_m[5]  = 8'h00;
      end
   endfunction

   function automatic void model_reset();
      m_loaded = 1'b0;
      q.delete();
      e_sv   = 1'b0;
      e_err  = 1'b0;
      e_data = 8'd0;
   endfunction

   function automatic void model_update(input bit cv, input bit bv, input bit bd);
      int len, val;
      bit hit;
      e_sv  = 1'b0;
      e_err = 1'b0;
      if (cv) begin
         m_hc = tbl_hc;
         m_m  = tbl_m;
         m_loaded = 1'b1;
         q.delete();
      end else if (m_loaded && bv) begin
         q.push_back(int'(bd));
         len = q.size();
         val = 0;
         foreach (q[k]) val = val * 2 + q[k];
         hit = 1'b0;
         for (int i = 0; i < 6; i++) begin
            if (!hit && int'(m_m[i] & 8'h1F) == (1 << len) - 1 &&
                int'(m_hc[i] & 8'h1F) == val) begin
               hit    = 1'b1;
               e_sv   = 1'b1;
               e_data = 8'(i + 1);
            end
         end
         if (hit) q.delete();
         else if (len == 5) begin
            e_err = ErrEn;
            q.delete();
         end
      end
   endfunction

   task automatic check(input string nm);
      n_vec++;
      if (bus.sym_valid !== e_sv || bus.sym_data !== e_data || bus.code_err !== e_err ||
          bus.table_ready !== m_loaded) begin
         n_err++;
         $display("FAIL %s: got sv=%b data=%0d err=%b rdy=%b, expected sv=%b data=%0d err=%b rdy=%b",
                  nm, bus.sym_valid, bus.sym_data, bus.code_err, bus.table_ready,
                  e_sv, e_data, e_err, m_loaded);
      end
      if (bus.sym_valid === 1'b1) got.push_back(int'(bus.sym_data));
      if (bus.code_err === 1'b1) got_err++;
   endtask

   task automatic step(input bit cv, input bit bv, input bit bd, input string nm);
      @(negedge clk);
      bus.code_valid = cv;
      bus.bit_valid  = bv;
      bus.bit_data   = bd;
      bus.HC1 = tbl_hc[0]; bus.HC2 = tbl_hc[1]; bus.HC3 = tbl_hc[2];
      bus.HC4 = tbl_hc[3]; bus.HC5 = tbl_hc[4]; bus.HC6 = tbl_hc[5];
      bus.M1  = tbl_m[0];  bus.M2  = tbl_m[1];  bus.M3  = tbl_m[2];
      bus.M4  = tbl_m[3];  bus.M5  = tbl_m[4];  bus.M6  = tbl_m[5];
      model_update(cv, bv, bd);
      @(posedge clk);
      #1;
      check(nm);
   endtask

   task automatic run_vec(input vec_t v);
      bit ok;
      load_t(v.off6);
      step(1'b1, 1'b0, 1'b0, {v.name, "_load"});
      got.delete();
      got_err = 0;
      for (int k = 0; k < v.nbits; k++) begin
         step(1'b0, 1'b1, v.bits[v.nbits-1-k], v.name);
         if (k + 1 == v.gap_at)
            for (int g = 0; g < v.gap_len; g++) step(1'b0, 1'b0, 1'b0, {v.name, "_gap"});
      end
      step(1'b0, 1'b0, 1'b0, {v.name, "_tail"});
      ok = (got.size() == v.nexp) && (got_err == v.exp_err);
      if (ok) for (int k = 0; k < v.nexp; k++) if (got[k] != int'(v.exp_s[k])) ok = 1'b0;
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s_symbols: got %0d symbols (first %0d) and %0d errors, expected %0d symbols (first %0d) and %0d errors",
                  v.name, got.size(), (got.size() > 0) ? got[0] : -1, got_err,
                  v.nexp, int'(v.exp_s[0]), v.exp_err);
      end
   endtask

   initial begin
      vecs.push_back('{"seq110",  1'b0, 3, 16'h0006, 0, 0,  1, {8'd0, 8'd0, 8'd0, 8'd3}, 0});
      vecs.push_back('{"stream",  1'b0, 9, 16'h005F, 0, 0,  4, {8'd6, 8'd2, 8'd1, 8'd1}, 0});
      vecs.push_back('{"gap",     1'b0, 4, 16'h000E, 2, 10, 1, {8'd0, 8'd0, 8'd0, 8'd4}, 0});
      vecs.push_back('{"badpfx",  1'b1, 6, 16'h003E, 0, 0,  1, {8'd0, 8'd0, 8'd0, 8'd1},
                       ErrEn ? 1 : 0});
      vecs.push_back('{"onebit",  1'b0, 4, 16'h0000, 0, 0,  4, {8'd1, 8'd1, 8'd1, 8'd1}, 0});
      vecs.push_back('{"sym5",    1'b0, 5, 16'h001E, 0, 0,  1, {8'd0, 8'd0, 8'd0, 8'd5}, 0});

      bus.code_valid = 1'b0;
      bus.bit_valid  = 1'b0;
      bus.bit_data   = 1'b0;
      load_t(1'b0);
      model_reset();
      reset = 1'b0;
      #12;
      check("reset_state");
      @(negedge clk);
      reset = 1'b1;

      // Bits before any table must be ignored
      for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, "idle_bits");

      foreach (vecs[i]) run_vec(vecs[i]);

      // Table reload with a simultaneous bit drops the bit and the partial code
      load_t(1'b0);
      step(1'b1, 1'b0, 1'b0, "reload_a");
      step(1'b0, 1'b1, 1'b1, "reload_b1");
      step(1'b0, 1'b1, 1'b1, "reload_b2");
      step(1'b1, 1'b1, 1'b1, "reload_cv");
      step(1'b0, 1'b1, 1'b0, "reload_sym1");
      n_vec++;
      if (bus.sym_data !== 8'd1) begin
         n_err++;
         $display("FAIL reload_data: got %0d, expected 1", bus.sym_data);
      end

      // Asynchronous reset while a 2-bit prefix is pending
      step(1'b0, 1'b1, 1'b1, "rst_p1");
      step(1'b0, 1'b1, 1'b1, "rst_p2");
      @(negedge clk);
      bus.bit_valid = 1'b0;
      #2 reset = 1'b0;
      model_reset();
      #1 check("async_reset");
      @(posedge clk);
      #1 check("reset_held");
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, "post_reset_ignored");
      step(1'b1, 1'b0, 1'b0, "post_reset_load");
      step(1'b0, 1'b1, 1'b0, "post_reset_sym1");

      // Random traffic against the model
      for (int c = 0; c < 600; c++) begin
         bit cv;
         cv = ($urandom_range(0, 39) == 0);
         if (cv) begin
            if ($urandom_range(0, 1) == 0) load_t(1'($urandom_range(0, 1)));
            else
               for (int i = 0; i < 6; i++) begin
                  tbl_hc[i] = 8'($urandom);
                  tbl_m[i]  = 8'((1 << $urandom_range(0, 6)) - 1);
               end
         end
         step(cv, ($urandom_range(0, 9) < 7), 1'($urandom), "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
